// File: rtl/wb_arbiter_if.sv
// Bus bundle between the three result sources, decode and the write-back arbiter.
interface wb_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              alu_valid, mem_valid, mul_valid;
    logic [REG_AW-1:0] alu_rd, mem_rd, mul_rd;
    logic [XLEN-1:0]   alu_data, mem_data, mul_data;
    logic              alu_ready, mem_ready, mul_ready;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;
    logic [REG_AW-1:0] chk_rs1, chk_rs2, chk_rd;
    logic              stall;
    logic              reg_write;
    logic [REG_AW-1:0] write_reg;
    logic [XLEN-1:0]   write_data;

    modport master (
        output alu_valid, mem_valid, mul_valid, alu_rd, mem_rd, mul_rd,
               alu_data, mem_data, mul_data, issue_valid, issue_rd,
               chk_rs1, chk_rs2, chk_rd,
        input  alu_ready, mem_ready, mul_ready, stall, reg_write, write_reg, write_data
    );

    modport slave (
        input  alu_valid, mem_valid, mul_valid, alu_rd, mem_rd, mul_rd,
               alu_data, mem_data, mul_data, issue_valid, issue_rd,
               chk_rs1, chk_rs2, chk_rd,
        output alu_ready, mem_ready, mul_ready, stall, reg_write, write_reg, write_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter for the register file write port, plus the
// pending-destination scoreboard that stalls decode on in-flight multi-cycle ops.
module wb_arbiter #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int NREG = 1 << REG_AW;

    logic [1:0]        ptr;
    logic [2:0]        req, gnt;
    logic              xfer;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [1:0]        ptr_nxt;
    logic [NREG-1:0]   pending, pending_nxt;
    logic              reg_write_p1;
    logic [REG_AW-1:0] write_reg_p1;
    logic [XLEN-1:0]   write_data_p1;

    // Search order starts at p and wraps modulo 3; p == 3 never occurs.
    function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
        logic [2:0] r;
        r = 3'b000;
        case (p)
            2'd1: begin
                if (v[1])      r = 3'b010;
                else if (v[2]) r = 3'b100;
                else if (v[0]) r = 3'b001;
            end
            2'd2: begin
                if (v[2])      r = 3'b100;
                else if (v[0]) r = 3'b001;
                else if (v[1]) r = 3'b010;
            end
            default: begin
                if (v[0])      r = 3'b001;
                else if (v[1]) r = 3'b010;
                else if (v[2]) r = 3'b100;
            end
        endcase
        return r;
    endfunction

    // Stage p0: combinational grant and winner select
    assign req  = {bus.mul_valid, bus.mem_valid, bus.alu_valid};
    assign gnt  = rr_pick(req, ptr);
    assign xfer = |gnt;

    assign bus.alu_ready = gnt[0];
    assign bus.mem_ready = gnt[1];
    assign bus.mul_ready = gnt[2];

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        ptr_nxt  = ptr;
        if (gnt[0]) begin
            sel_rd = bus.alu_rd; sel_data = bus.alu_data; ptr_nxt = 2'd1;
        end else if (gnt[1]) begin
            sel_rd = bus.mem_rd; sel_data = bus.mem_data; ptr_nxt = 2'd2;
        end else if (gnt[2]) begin
            sel_rd = bus.mul_rd; sel_data = bus.mul_data; ptr_nxt = 2'd0;
        end
    end

    // Clear on commit first so a same-cycle issue to the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (reg_write_p1)
            pending_nxt[write_reg_p1] = 1'b0;
        if (bus.issue_valid && (bus.issue_rd != '0))
            pending_nxt[bus.issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Stage p1: registered register-file write and scoreboard state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr           <= 2'd0;
            pending       <= '0;
            reg_write_p1  <= 1'b0;
            write_reg_p1  <= '0;
            write_data_p1 <= '0;
        end else begin
            ptr          <= ptr_nxt;
            pending      <= pending_nxt;
            reg_write_p1 <= xfer && (sel_rd != '0);
            if (xfer && (sel_rd != '0)) begin
                write_reg_p1  <= sel_rd;
                write_data_p1 <= sel_data;
            end
        end
    end

    assign bus.reg_write  = reg_write_p1;
    assign bus.write_reg  = write_reg_p1;
    assign bus.write_data = write_data_p1;

    assign bus.stall = pending[bus.chk_rs1] | pending[bus.chk_rs2] | pending[bus.chk_rd];
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter with a queue/array reference model.
module tb_wb_arbiter;
    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] dat;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(32), .REG_AW(5)) bus();
    wb_arbiter #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;
    wr_t exp_q[$];

    // Reference model state
    bit          rv[3];
    logic [4:0]  rrd[3];
    logic [31:0] rdat[3];
    int          mptr = 0;
    bit          pend[32];
    bit          mwe = 1'b0;
    logic [4:0]  mrd = '0;
    logic [31:0] mdat = '0;
    logic [4:0]  c1 = '0, c2 = '0, c3 = '0;

    task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (mptr + k) % 3;
            if (rv[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive(input bit iv, input logic [4:0] ird);
        bus.alu_valid = rv[0]; bus.alu_rd = rrd[0]; bus.alu_data = rdat[0];
        bus.mem_valid = rv[1]; bus.mem_rd = rrd[1]; bus.mem_data = rdat[1];
        bus.mul_valid = rv[2]; bus.mul_rd = rrd[2]; bus.mul_data = rdat[2];
        bus.issue_valid = iv;  bus.issue_rd = ird;
        bus.chk_rs1 = c1; bus.chk_rs2 = c2; bus.chk_rd = c3;
    endtask

    // mode: 0 plain cycle, 1 async reset pulse mid-cycle, 2 release initial reset
    task automatic step(input bit iv, input logic [4:0] ird, input int mode);
        int g;
        logic [2:0] exp_rdy;
        @(negedge clk);
        drive(iv, ird);
        if (mode == 2) rst = 1'b1;
        if (mode == 1) begin
            #1 rst = 1'b0;
            #1;
            compare("rst_reg_write", 64'(bus.reg_write), 64'(0));
            compare("rst_write_reg", 64'(bus.write_reg), 64'(0));
            compare("rst_write_data", 64'(bus.write_data), 64'(0));
            compare("rst_stall", 64'(bus.stall), 64'(0));
            mptr = 0; mwe = 1'b0; mrd = '0; mdat = '0;
            for (int r = 0; r < 32; r++) pend[r] = 1'b0;
            #1 rst = 1'b1;
        end
        #1;
        g = model_pick();
        exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
        compare("ready", 64'({bus.mul_ready, bus.mem_ready, bus.alu_ready}), 64'(exp_rdy));
        compare("stall", 64'(bus.stall), 64'(pend[c1] | pend[c2] | pend[c3]));
        if (mwe) pend[mrd] = 1'b0;
        if (iv && ird != 0) pend[ird] = 1'b1;
        if (g >= 0) begin
            mptr = (g + 1) % 3;
            if (rrd[g] != 0) begin
                mwe = 1'b1; mrd = rrd[g]; mdat = rdat[g];
            end else
                mwe = 1'b0;
            rv[g] = 1'b0;
        end else
            mwe = 1'b0;
        exp_q.push_back('{we: mwe, rd: mrd, dat: mdat});
    endtask

    // Monitor: one expected register-file write slot per clock edge
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            if (mon_on) begin
                #1;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_queue: got output with empty expectation queue at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    compare("reg_write", 64'(bus.reg_write), 64'(e.we));
                    compare("write_reg", 64'(bus.write_reg), 64'(e.rd));
                    compare("write_data", 64'(bus.write_data), 64'(e.dat));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        // Reset held with every requester valid
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b1; rrd[i] = 5'(i + 1); rdat[i] = 32'hA0A0_0000 + 32'(i);
        end
        drive(1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        compare("hold_reg_write", 64'(bus.reg_write), 64'(0));
        compare("hold_write_reg", 64'(bus.write_reg), 64'(0));
        compare("hold_write_data", 64'(bus.write_data), 64'(0));
        compare("hold_ready", 64'({bus.mul_ready, bus.mem_ready, bus.alu_ready}), 64'(3'b001));
        compare("hold_stall", 64'(bus.stall), 64'(0));
        mon_on = 1'b1;

        // Round-robin with all three continuously valid
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 3; i++)
                if (!rv[i]) begin
                    rv[i] = 1'b1; rrd[i] = 5'(i + 1); rdat[i] = 32'hA0A0_0000 + 32'(i);
                end
            step(1'b0, 5'd0, (n == 0) ? 2 : 0);
        end
        for (int i = 0; i < 3; i++) rv[i] = 1'b0;

        // Lone MEM request, then an x0 discard from the ALU
        rv[1] = 1'b1; rrd[1] = 5'd7; rdat[1] = 32'hDEADBEEF;
        step(1'b0, 5'd0, 0);
        step(1'b0, 5'd0, 0);
        rv[0] = 1'b1; rrd[0] = 5'd0; rdat[0] = 32'd5;
        step(1'b0, 5'd0, 0);
        step(1'b0, 5'd0, 0);

        // Scoreboard on x9: stall until the MUL write commits
        step(1'b1, 5'd9, 0);
        c2 = 5'd9;
        repeat (3) step(1'b0, 5'd0, 0);
        rv[2] = 1'b1; rrd[2] = 5'd9; rdat[2] = 32'h1234_5678;
        repeat (3) step(1'b0, 5'd0, 0);

        // Re-issue of x9 in the same cycle its previous write clears it
        step(1'b1, 5'd9, 0);
        rv[2] = 1'b1; rrd[2] = 5'd9; rdat[2] = 32'h0BAD_F00D;
        step(1'b0, 5'd0, 0);
        step(1'b1, 5'd9, 0);
        repeat (2) step(1'b0, 5'd0, 0);

        // Asynchronous reset pulse with x9 pending and writes in flight
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b1; rrd[i] = 5'(i + 4); rdat[i] = 32'hC0DE_0000 + 32'(i);
        end
        step(1'b0, 5'd0, 0);
        step(1'b0, 5'd0, 1);
        step(1'b0, 5'd0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            bit          iv;
            logic [4:0]  ird;
            for (int i = 0; i < 3; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1; rrd[i] = 5'($urandom_range(0, 15)); rdat[i] = $urandom;
                end else if (rv[i] && $urandom_range(0, 15) == 0)
                    rv[i] = 1'b0;
            end
            ird = 5'($urandom_range(1, 15));
            iv  = ($urandom_range(0, 3) == 0) && !pend[ird];
            c1 = 5'($urandom_range(0, 15));
            c2 = 5'($urandom_range(0, 15));
            c3 = 5'($urandom_range(0, 15));
            step(iv, ird, 0);
        end

        for (int i = 0; i < 3; i++) rv[i] = 1'b0;
        repeat (2) step(1'b0, 5'd0, 0);
        @(posedge clk);
        #2;
        mon_on = 1'b0;
        compare("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and register scoreboard for the integer register file write port. Three result sources compete for the single write port: the single-cycle ALU, the load path and the multi-cycle MUL/FPU unit. The block grants the port round-robin and registers the winning write toward the register file. It also tracks destination registers of in-flight multi-cycle operations and raises a decode stall when a new instruction touches one of them.

## Interface
- XLEN, 32, data width of write data
- REG_AW, 5, register address width (2**REG_AW registers)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- alu_valid / mem_valid / mul_valid  input  1 each  requester has a result
- alu_rd / mem_rd / mul_rd  input  REG_AW each  destination register
- alu_data / mem_data / mul_data  input  XLEN each  result value
- alu_ready / mem_ready / mul_ready  output  1 each  grant; transfer = valid & ready
- issue_valid  input  1  decode issues a multi-cycle op this cycle
- issue_rd  input  REG_AW  destination of the issued op
- chk_rs1, chk_rs2, chk_rd  input  REG_AW each  operands of the instruction in decode
- stall  output  1  decode must hold
- reg_write  output  1  register file write enable (registered)
- write_reg  output  REG_AW  register file write address (registered)
- write_data  output  XLEN  register file write data (registered)

## Operation
- Requester indices: ALU=0, MEM=1, MUL=2.
- Round-robin pointer `ptr` (2 bits, values 0..2) names the highest-priority requester. Search order is ptr, ptr+1, ptr+2, mod 3.
- Grant is combinational. At most one `*_ready` is high, and only to a valid requester. With no valid requester, all readys are 0.
- On a transfer by requester i, `ptr` becomes (i+1) mod 3 at the next edge. With no transfer, `ptr` holds.
- Requesters hold valid, rd and data stable until ready. Dropping valid before grant is allowed; the request is simply withdrawn.
- On a transfer with rd != 0:
  - next cycle: reg_write=1, write_reg=rd, write_data=data.
- On a transfer with rd == 0:
  - the request is accepted and consumed;
  - next cycle: reg_write=0; write_reg and write_data are don't-care but hold their previous values.
- No transfer: reg_write=0 next cycle.
- Scoreboard is a 2**REG_AW-bit `pending` vector. Bit 0 is always 0.
  - Set: issue_valid & issue_rd != 0 sets pending[issue_rd] at the edge.
  - Clear: reg_write=1 clears pending[write_reg] at the edge, i.e. the edge the register file commits.
  - Same register set and cleared in one cycle: set wins.
- stall = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd] (combinational). Index 0 never stalls.
- Decode must not issue to a pending rd; the stall on chk_rd enforces this. Behaviour on a violating issue: the bit stays set.

## Timing
- Reset (rst=0, asynchronous): reg_write=0, write_reg=0, write_data=0, ptr=0, pending all 0. All readys then follow the valids combinationally with ptr=0.
- Grant to register-file write latency: 1 cycle. Throughput: one write per cycle.
- Starvation bound: a continuously valid requester is granted within 3 cycles.
- stall deasserts in the cycle after reg_write=1 for the pending register. Register file reads in that cycle see the new value.
- Reset asserted mid-operation: all in-flight grants are lost, and pending is cleared. Requesters must re-present after reset.

## Test plan
- Reset: hold rst=0 with all valids high.
  - Required: reg_write=0, outputs 0, alu_ready=1 only.
  - After release, the first write is the ALU result.
- Round-robin: all three valid continuously with rd=1/2/3 and data A/B/C.
  - Required: write_reg sequence 1,2,3,1,2,3 on consecutive cycles.
  - Required: each ready pulses once per 3 cycles.
- Single requester: mem_valid only, rd=7, data=0xDEADBEEF.
  - Required: mem_ready=1 immediately; next cycle reg_write=1, write_reg=7, write_data=0xDEADBEEF.
- x0 discard: alu_valid, rd=0, data=5.
  - Required: alu_ready=1; next cycle reg_write=0; pending unchanged.
- Scoreboard: issue_valid with issue_rd=9, then chk_rs2=9.
  - Required: stall=1 until the MUL transfer with rd=9.
  - Required: reg_write=1 for write_reg=9 appears, then stall=0 the following cycle.
  - Also: issue_rd=9 coincident with clear of 9 -> pending[9] stays 1.
- Async reset mid-stream: pulse rst low between edges while pending[9]=1 and writes are in flight.
  - Required: immediate reg_write=0, stall=0, ptr=0.
